// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared types and defaults for the ADC scan controller
package adc_scan_pkg;

    localparam int ADC_W           = 12;
    localparam int DEF_N_CH        = 4;
    localparam int DEF_SETTLE_CYC  = 200;
    localparam int DEF_TIMEOUT_CYC = 2000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_STORE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_scan_rr.sv
// rtl/adc_scan_rr.sv - round-robin next-channel search over the channel mask
module adc_scan_rr
    import adc_scan_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    localparam int CW   = $clog2(N_CH)
)(
    input  logic [N_CH-1:0] i_mask,
    input  logic [CW-1:0]   i_last_ch,
    output logic [CW-1:0]   o_next_ch,
    output logic            o_any
);

    logic          w_found;
    logic [CW-1:0] w_idx;

    // Search starts one above the last channel; i == N_CH lands back on it.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = '0;
        o_next_ch = i_last_ch;
        for (int i = 1; i <= N_CH; i++) begin
            w_idx = CW'((int'(i_last_ch) + i) % N_CH);
            if (!w_found && i_mask[w_idx]) begin
                w_found   = 1'b1;
                o_next_ch = w_idx;
            end
        end
    end

    assign o_any = |i_mask;

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - round-robin ADC channel scanner; ADC_SCAN_LIMIT_EN adds per-channel high-limit alarms
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter  int N_CH        = DEF_N_CH,
    parameter  int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int CW          = $clog2(N_CH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic [N_CH-1:0]  ch_mask,
    output logic             conv_start,
    input  logic             conv_done,
    input  logic [ADC_W-1:0] conv_data,
    output logic [CW-1:0]    mux_sel,
    output logic             res_valid,
    output logic [CW-1:0]    res_ch,
    output logic [ADC_W-1:0] res_data,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
`ifdef ADC_SCAN_LIMIT_EN
    ,
    input  logic [N_CH*ADC_W-1:0] lim_hi,
    output logic [N_CH-1:0]       lim_alarm
`endif
);

    localparam int                CNT_W        = $clog2(max_int(SETTLE_CYC, TIMEOUT_CYC) + 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CW-1:0]    r_mux_sel;
    logic [CW-1:0]    r_last;
    logic             r_conv_start;
    logic             r_res_valid;
    logic [CW-1:0]    r_res_ch;
    logic [ADC_W-1:0] r_res_data;
    logic             r_timeout_err;

    logic             w_sel;
    logic             w_cnt_clr;
    logic             w_start;
    logic             w_capture;
    logic             w_timeout;
    logic [CW-1:0]    w_next_ch;
    logic             w_any;

    adc_scan_rr #(.N_CH(N_CH)) u_rr (
        .i_mask    (ch_mask),
        .i_last_ch (r_last),
        .o_next_ch (w_next_ch),
        .o_any     (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (scan_en && w_any) begin
                    w_sel       = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!scan_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A conv_done on the final timeout cycle still counts as success.
                if (conv_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_STORE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STORE: begin
                if (scan_en && w_any) begin
                    w_sel       = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_mux_sel     <= '0;
            r_last        <= CW'(N_CH - 1);
            r_conv_start  <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= '0;
            r_res_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state == ST_SETTLE || r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_sel) begin
                r_mux_sel <= w_next_ch;
                r_last    <= w_next_ch;
            end
            r_conv_start <= w_start;
            r_res_valid  <= w_capture;
            if (w_capture) begin
                r_res_ch   <= r_mux_sel;
                r_res_data <= conv_data;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

`ifdef ADC_SCAN_LIMIT_EN
    logic [N_CH-1:0] r_lim_alarm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lim_alarm <= '0;
        end else if (r_state == ST_STORE) begin
            r_lim_alarm[r_res_ch] <= (r_res_data > lim_hi[int'(r_res_ch)*ADC_W +: ADC_W]);
        end
    end

    assign lim_alarm = r_lim_alarm;
`endif

    assign conv_start  = r_conv_start;
    assign mux_sel     = r_mux_sel;
    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_data    = r_res_data;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - directed scoreboard bench for adc_scan_ctrl
module tb_adc_scan_ctrl;
    import adc_scan_pkg::*;

    localparam int N_CH        = 4;
    localparam int SETTLE_CYC  = 20;
    localparam int TIMEOUT_CYC = 100;
    localparam int LAT         = 50;
    localparam int CW          = $clog2(N_CH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             scan_en;
    logic [N_CH-1:0]  ch_mask;
    logic             conv_start;
    logic             conv_done = 1'b0;
    logic [ADC_W-1:0] conv_data = '0;
    logic [CW-1:0]    mux_sel;
    logic             res_valid;
    logic [CW-1:0]    res_ch;
    logic [ADC_W-1:0] res_data;
    logic             busy;
    logic             timeout_err;
    logic             err_clr;
`ifdef ADC_SCAN_LIMIT_EN
    logic [N_CH*ADC_W-1:0] lim_hi = {12'hFFF, 12'hFFF, 12'hFFF, 12'h800};
    logic [N_CH-1:0]       lim_alarm;
`endif

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_res = 0;
    int n_start = 0;
    int done_cyc = -10;
    int last_res_cyc = -1;
    int last_period = 0;
    bit adc_on = 1'b1;
    int adc_lat = LAT;
    bit use_force = 1'b0;
    logic [ADC_W-1:0] force_data = '0;
    logic [CW-1:0] m_ch;

    adc_scan_ctrl #(
        .N_CH        (N_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .ch_mask     (ch_mask),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .mux_sel     (mux_sel),
        .res_valid   (res_valid),
        .res_ch      (res_ch),
        .res_data    (res_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
`ifdef ADC_SCAN_LIMIT_EN
        ,
        .lim_hi      (lim_hi),
        .lim_alarm   (lim_alarm)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int ch, input int data);
        exp_t e;
        e.ch = ch;
        e.data = data;
        sb.push_back(e);
    endfunction

    // ADC core model: answers each conv_start adc_lat cycles later.
    always begin
        @(negedge clk);
        if (conv_start === 1'b1 && adc_on) begin
            m_ch = mux_sel;
            repeat (adc_lat) @(negedge clk);
            conv_data = use_force ? force_data : ADC_W'(12'h100 + m_ch);
            conv_done = 1'b1;
            done_cyc  = cyc;
            @(negedge clk);
            conv_done = 1'b0;
        end
    end

    // Result monitor: pops the scoreboard on every res_valid.
    always @(negedge clk) begin
        exp_t e;
        if (conv_start === 1'b1) n_start++;
        if (res_valid === 1'b1) begin
            n_res++;
            chk("res_latency", cyc, done_cyc + 1);
            chk("res_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("res_ch", res_ch, e.ch);
                chk("res_data", res_data, e.data);
            end
            if (last_res_cyc >= 0) last_period = cyc - last_res_cyc;
            last_res_cyc = cyc;
        end
    end

    task automatic do_reset();
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_res_cyc = -1;
        @(negedge clk);
    endtask

    task automatic wait_res(input int target, input int budget, input string tag);
        int t = 0;
        while (n_res < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, n_res >= target, 1'b1);
    endtask

    task automatic wait_start(input int budget, output int t0);
        int t = 0;
        while (conv_start !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", conv_start, 1'b1);
        t0 = cyc;
    endtask

    initial begin
        int s;
        int base;
        int t0;
        int t1;
        int t;
        rst_n   = 1'b0;
        scan_en = 1'b0;
        ch_mask = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_ch", res_ch, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
`ifdef ADC_SCAN_LIMIT_EN
        chk("rst_lim_alarm", lim_alarm, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_without_scan_en", busy, 0);

        // Full mask: 0,1,2,3,0 then drop scan_en during SETTLE.
        ch_mask = 4'b1111;
        for (int i = 0; i < 5; i++) push(i % 4, 'h100 + i % 4);
        scan_en = 1'b1;
        wait_res(5, 600, "full_scan_done");
        chk("rr_period", last_period, SETTLE_CYC + LAT + 2);
        repeat (2) @(negedge clk);
        scan_en = 1'b0;
        s = n_start;
        repeat (30) @(negedge clk);
        chk("settle_drop_no_start", n_start, s);
        chk("settle_drop_idle", busy, 0);

        // Sparse mask 1010: 1,3,1, then mask cleared mid-conversion.
        do_reset();
        base = n_res;
        ch_mask = 4'b1010;
        push(1, 'h101);
        push(3, 'h103);
        push(1, 'h101);
        scan_en = 1'b1;
        wait_res(base + 2, 300, "sparse_two_done");
        repeat (40) @(negedge clk);
        ch_mask = 4'b0000;
        wait_res(base + 3, 200, "sparse_third_done");
        repeat (5) @(negedge clk);
        chk("mask_zero_idle", busy, 0);
        repeat (80) @(negedge clk);
        chk("mask_zero_no_more_res", n_res, base + 3);
        scan_en = 1'b0;

        // Timeout without conv_done, then err_clr colliding with a second timeout.
        do_reset();
        base = n_res;
        adc_on = 1'b0;
        ch_mask = 4'b0001;
        scan_en = 1'b1;
        wait_start(100, t0);
        t = 0;
        while (timeout_err !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        t1 = cyc;
        scan_en = 1'b0;
        chk("timeout_set", timeout_err, 1);
        // WAIT spans TIMEOUT_CYC cycles after the conv_start cycle.
        chk("timeout_delay", t1 - t0, TIMEOUT_CYC + 1);
        chk("timeout_no_res", n_res, base);
        @(negedge clk);
        chk("timeout_idle", busy, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_clears", timeout_err, 0);
        scan_en = 1'b1;
        wait_start(100, t0);
        repeat (TIMEOUT_CYC) @(negedge clk);
        chk("timeout_not_early", timeout_err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        scan_en = 1'b0;
        chk("timeout_beats_clr", timeout_err, 1);
        adc_on = 1'b1;

        // conv_done on the last allowed WAIT cycle wins over the timeout.
        do_reset();
        base = n_res;
        adc_lat = TIMEOUT_CYC;
        ch_mask = 4'b0001;
        push(0, 'h100);
        scan_en = 1'b1;
        wait_start(100, t0);
        scan_en = 1'b0;
        wait_res(base + 1, 200, "edge_done_res");
        chk("edge_done_no_timeout", timeout_err, 0);
        adc_lat = LAT;
        repeat (5) @(negedge clk);

        // scan_en dropped in WAIT: exactly one more result, no new start.
        do_reset();
        base = n_res;
        ch_mask = 4'b0100;
        push(2, 'h102);
        scan_en = 1'b1;
        wait_start(100, t0);
        repeat (10) @(negedge clk);
        scan_en = 1'b0;
        s = n_start;
        wait_res(base + 1, 200, "wait_drop_res");
        repeat (40) @(negedge clk);
        chk("wait_drop_one_res", n_res, base + 1);
        chk("wait_drop_no_start", n_start, s);
        chk("wait_drop_idle", busy, 0);

        // Reset in WAIT clears outputs at once; the late conv_done is ignored.
        base = n_res;
        ch_mask = 4'b0010;
        scan_en = 1'b1;
        wait_start(100, t0);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mux_sel", mux_sel, 0);
        chk("arst_res_ch", res_ch, 0);
        chk("arst_res_data", res_data, 0);
        chk("arst_conv_start", conv_start, 0);
        chk("arst_res_valid", res_valid, 0);
        scan_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        chk("late_done_ignored", n_res, base);
        chk("late_done_idle", busy, 0);

`ifdef ADC_SCAN_LIMIT_EN
        do_reset();
        base = n_res;
        use_force = 1'b1;
        force_data = 12'h801;
        push(0, 'h801);
        ch_mask = 4'b0001;
        scan_en = 1'b1;
        wait_res(base + 1, 200, "lim_first_res");
        force_data = 12'h7FF;
        push(0, 'h7FF);
        repeat (2) @(negedge clk);
        chk("lim_alarm_high", lim_alarm[0], 1);
        wait_res(base + 2, 200, "lim_second_res");
        scan_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("lim_alarm_low", lim_alarm[0], 0);
        use_force = 1'b0;
        repeat (5) @(negedge clk);
`endif

        chk("sb_final_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter N_CH, 4, number of multiplexed analog channels (2..8).
REQ-002 SHALL have parameter SETTLE_CYC, 200, clk cycles of mux settling before each conversion start.
REQ-003 SHALL have parameter TIMEOUT_CYC, 2000, clk cycles allowed between conv_start and conv_done.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port scan_en  in  1  level; 1 = run continuous round-robin scan.
REQ-007 SHALL have port ch_mask  in  N_CH  per-channel enable; bit i = channel i scanned.
REQ-008 SHALL have port conv_start  out  1  one-cycle pulse requesting one conversion from the serial ADC core.
REQ-009 SHALL have port conv_done  in  1  one-cycle pulse from the ADC core; conv_data valid in the same cycle.
REQ-010 SHALL have port conv_data  in  12  conversion result.
REQ-011 SHALL have port mux_sel  out  $clog2(N_CH)  external analog mux select, registered.
REQ-012 SHALL have ports res_valid (out, 1), res_ch (out, $clog2(N_CH)) and res_data (out, 12): one-cycle result strobe with channel tag.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port timeout_err  out  1  sticky conversion-timeout flag.
REQ-015 SHALL have port err_clr  in  1  clears timeout_err.

Function
REQ-016 SHALL implement the states IDLE, SETTLE, START, WAIT and STORE.
REQ-017 In IDLE with scan_en=1 and ch_mask!=0, the block SHALL load mux_sel with the next enabled channel and go to SETTLE.
REQ-018 SETTLE SHALL count SETTLE_CYC cycles and then go to START.
REQ-019 START SHALL assert conv_start for exactly one cycle, zero the timeout counter, and go to WAIT.
REQ-020 WAIT SHALL go to STORE on conv_done, or go to IDLE with timeout_err set when the counter reaches TIMEOUT_CYC-1 with no conv_done.
REQ-021 If conv_done and the timeout occur in the same cycle, conv_done SHALL win.
REQ-022 STORE SHALL assert res_valid for one cycle with res_ch=mux_sel and res_data=conv_data captured at conv_done.
REQ-023 After STORE, the block SHALL select the next channel and go to SETTLE when scan_en=1 and ch_mask!=0; otherwise it SHALL go to IDLE.
REQ-024 Next-channel selection SHALL be round-robin, searching upward from the last channel with wrap from N_CH-1 to 0; a single enabled channel re-selects itself.
REQ-025 ch_mask SHALL be sampled only at channel selection; changes mid-conversion SHALL NOT abort the conversion.
REQ-026 scan_en deassertion in SETTLE SHALL return to IDLE without conv_start; in START or WAIT the conversion SHALL complete (result still delivered).
REQ-027 conv_done outside WAIT SHALL be ignored.
REQ-028 err_clr SHALL clear timeout_err; if err_clr and a new timeout coincide, the flag SHALL end set.
REQ-029 Latency from conv_done to res_valid SHALL be 1 cycle.
REQ-030 Steady-state channel period SHALL be SETTLE_CYC + 1 + t_conv + 1 cycles.

Reset
REQ-031 While rst_n=0, the block SHALL hold state=IDLE, mux_sel=0, conv_start=0, res_valid=0, res_ch=0, res_data=0, busy=0, timeout_err=0 and all counters at 0; the round-robin pointer SHALL reset so that channel 0 is searched first.
REQ-032 Reset asserted mid-conversion SHALL abandon the conversion; a late conv_done after reset release SHALL be ignored.

Configuration
REQ-033 The macro ADC_SCAN_LIMIT_EN SHALL enable the limit-check feature.
REQ-034 With ADC_SCAN_LIMIT_EN defined, the block SHALL add the ports lim_hi (in, N_CH*12) and lim_alarm (out, N_CH).
REQ-035 With ADC_SCAN_LIMIT_EN defined, in STORE lim_alarm[ch] SHALL be set when res_data > lim_hi[ch] and cleared otherwise; lim_alarm SHALL reset to 0.
REQ-036 Without ADC_SCAN_LIMIT_EN, those ports and that logic SHALL be absent.

Structure
REQ-037 Package adc_scan_pkg SHALL hold the state enum, ADC_W=12, and the default parameter constants.
REQ-038 The next-channel search SHALL live in the combinational sub-module adc_scan_rr (inputs: mask, last channel; outputs: next channel, any).

Verification
REQ-039 With N_CH=4, ch_mask=4'b1111, scan_en=1 and a model returning 0x100+ch after 50 cycles, res_ch SHALL sequence 0,1,2,3,0 and res_data SHALL equal 0x100..0x103.
REQ-040 With ch_mask=4'b1010, channels SHALL sequence 1,3,1; then ch_mask=0 -> IDLE after the current result and busy=0.
REQ-041 With no conv_done, timeout_err SHALL set TIMEOUT_CYC cycles after conv_start with no res_valid; err_clr SHALL then clear it.
REQ-042 With scan_en dropped in WAIT, exactly one more res_valid SHALL occur before IDLE; with scan_en dropped in SETTLE, no conv_start SHALL occur.
REQ-043 With rst_n pulsed low in WAIT, all outputs SHALL be 0 immediately, and a following conv_done SHALL produce no res_valid.
REQ-044 With ADC_SCAN_LIMIT_EN, lim_hi[ch0]=0x800 and data 0x801 then 0x7FF: lim_alarm[0] SHALL go 1 then 0.
